// File: rtl/crc8_frame_check_pkg.sv
// Shared frame geometry, FSM state encoding and counter helper for the
// CRC-8 framed-stream checker.
package crc8_frame_check_pkg;

  localparam int unsigned FRAME_LEN     = 10;
  localparam int unsigned CRC_IDX       = 7;
  localparam int unsigned PAYLOAD_BYTES = 7;
  localparam int unsigned TRAILER_BYTES = 2;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned PAYLOAD_W = PAYLOAD_BYTES * BYTE_W;
  localparam int unsigned TRAILER_W = TRAILER_BYTES * BYTE_W;

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    CHECK,
    TRAILER
  } state_e;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/crc8_frame_check_crc.sv
// One byte step of an MSB-first, non-reflected CRC-8 (no final XOR).
module crc8_byte_next
  import crc8_frame_check_pkg::*;
#(
  parameter logic [BYTE_W-1:0] POLYNOMIAL = 8'h07
) (
  input  logic [BYTE_W-1:0] crc_i,
  input  logic [BYTE_W-1:0] data_i,
  output logic [BYTE_W-1:0] crc_o
);

  logic [BYTE_W-1:0] c;

  always_comb begin
    c = crc_i ^ data_i;
    for (int b = 0; b < int'(BYTE_W); b++) begin
      c = c[BYTE_W-1] ? ({c[BYTE_W-2:0], 1'b0} ^ POLYNOMIAL) : {c[BYTE_W-2:0], 1'b0};
    end
    crc_o = c;
  end

endmodule

// File: rtl/crc8_frame_check.sv
// Receives a byte stream of fixed 10-byte frames, checks the CRC-8 in byte 7
// and publishes payload, trailer, status and saturating error counters.
module crc8_frame_check
  import crc8_frame_check_pkg::*;
#(
  parameter logic [BYTE_W-1:0] POLYNOMIAL = 8'h07,
  parameter logic [BYTE_W-1:0] INITIAL    = 8'hFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BYTE_W-1:0]    data_i,
  input  logic                 valid_i,
  input  logic                 sof_i,
  output logic [PAYLOAD_W-1:0] payload_o,
  output logic [TRAILER_W-1:0] trailer_o,
  output logic                 frame_valid_o,
  output logic                 crc_err_o,
  output logic [CNT_W-1:0]     err_count_o,
  output logic [CNT_W-1:0]     sync_loss_o
);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [BYTE_W-1:0]    crc_q, crc_d;
  logic [PAYLOAD_W-1:0] pay_sr_q, pay_sr_d;
  logic [BYTE_W-1:0]    byte8_q, byte8_d;
  logic                 mismatch_q, mismatch_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [TRAILER_W-1:0] trailer_q, trailer_d;
  logic                 frame_valid_q, frame_valid_d;
  logic                 crc_err_q, crc_err_d;
  logic [CNT_W-1:0]     err_count_q, err_count_d;
  logic [CNT_W-1:0]     sync_loss_q, sync_loss_d;

  logic [BYTE_W-1:0]    crc_seed_c;
  logic [BYTE_W-1:0]    crc_next_c;
  logic                 expect_sof_c;

  // Any accepted sof byte restarts the CRC from the seed.
  assign crc_seed_c   = sof_i ? INITIAL : crc_q;
  assign expect_sof_c = (state_q == HUNT) || ((state_q == PAYLOAD) && (idx_q == '0));

  crc8_byte_next #(
    .POLYNOMIAL(POLYNOMIAL)
  ) u_crc_byte (
    .crc_i (crc_seed_c),
    .data_i(data_i),
    .crc_o (crc_next_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= HUNT;
      idx_q         <= '0;
      crc_q         <= INITIAL;
      pay_sr_q      <= '0;
      byte8_q       <= '0;
      mismatch_q    <= 1'b0;
      payload_q     <= '0;
      trailer_q     <= '0;
      frame_valid_q <= 1'b0;
      crc_err_q     <= 1'b0;
      err_count_q   <= '0;
      sync_loss_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      crc_q         <= crc_d;
      pay_sr_q      <= pay_sr_d;
      byte8_q       <= byte8_d;
      mismatch_q    <= mismatch_d;
      payload_q     <= payload_d;
      trailer_q     <= trailer_d;
      frame_valid_q <= frame_valid_d;
      crc_err_q     <= crc_err_d;
      err_count_q   <= err_count_d;
      sync_loss_q   <= sync_loss_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    crc_d         = crc_q;
    pay_sr_d      = pay_sr_q;
    byte8_d       = byte8_q;
    mismatch_d    = mismatch_q;
    payload_d     = payload_q;
    trailer_d     = trailer_q;
    frame_valid_d = 1'b0;
    crc_err_d     = crc_err_q;
    err_count_d   = err_count_q;
    sync_loss_d   = sync_loss_q;

    if (valid_i) begin
      if (sof_i) begin
        // sof mid-frame aborts the frame; the byte becomes byte 0 either way.
        if (!expect_sof_c) begin
          sync_loss_d = sat_inc(sync_loss_q);
        end
        state_d  = PAYLOAD;
        idx_d    = IDX_W'(1);
        crc_d    = crc_next_c;
        pay_sr_d = PAYLOAD_W'(data_i);
      end else begin
        case (state_q)
          HUNT: begin
            state_d = HUNT;
          end
          PAYLOAD: begin
            if (idx_q == '0) begin
              sync_loss_d = sat_inc(sync_loss_q);
              state_d     = HUNT;
            end else begin
              crc_d    = crc_next_c;
              pay_sr_d = {pay_sr_q[PAYLOAD_W-BYTE_W-1:0], data_i};
              idx_d    = idx_q + IDX_W'(1);
              if (idx_q == IDX_W'(CRC_IDX - 1)) begin
                state_d = CHECK;
              end
            end
          end
          CHECK: begin
            mismatch_d = (data_i != crc_q);
            idx_d      = idx_q + IDX_W'(1);
            state_d    = TRAILER;
          end
          TRAILER: begin
            if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
              frame_valid_d = 1'b1;
              payload_d     = pay_sr_q;
              trailer_d     = {byte8_q, data_i};
              crc_err_d     = mismatch_q;
              if (mismatch_q) begin
                err_count_d = sat_inc(err_count_q);
              end
              state_d = PAYLOAD;
              idx_d   = '0;
              crc_d   = INITIAL;
            end else begin
              byte8_d = data_i;
              idx_d   = idx_q + IDX_W'(1);
            end
          end
          default: begin
            state_d = HUNT;
          end
        endcase
      end
    end
  end

  assign payload_o     = payload_q;
  assign trailer_o     = trailer_q;
  assign frame_valid_o = frame_valid_q;
  assign crc_err_o     = crc_err_q;
  assign err_count_o   = err_count_q;
  assign sync_loss_o   = sync_loss_q;

endmodule
